// File: rtl/dataflow_frame_sequencer_if.sv
// Control bundle between the frame sequencer, the host ap_ctrl_hs port and
// the producer (P0) / consumer (P1) process instances.
interface dataflow_frame_sequencer_if #(
    parameter int CNT_W = 16
);
    // Handshake rule for every start/ready pair: a transfer (accept event)
    // happens on a rising edge where start and ready are both high; start is
    // raised independently of ready, and ready may depend combinationally on start.
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_idle;
    logic             p0_start;
    logic             p0_ready;
    logic             p0_done;
    logic             p0_idle;
    logic             p1_start;
    logic             p1_ready;
    logic             p1_done;
    logic             p1_idle;
    logic [3:0]       tokens;
    logic [CNT_W-1:0] frames_done;
    logic             clr_stall;
    logic             stall;
    logic [1:0]       stall_vec;

    modport master (
        output ap_start, p0_ready, p0_done, p0_idle,
               p1_ready, p1_done, p1_idle, clr_stall,
        input  ap_ready, ap_done, ap_idle, p0_start, p1_start,
               tokens, frames_done, stall, stall_vec
    );

    modport slave (
        input  ap_start, p0_ready, p0_done, p0_idle,
               p1_ready, p1_done, p1_idle, clr_stall,
        output ap_ready, ap_done, ap_idle, p0_start, p1_start,
               tokens, frames_done, stall, stall_vec
    );
endinterface

// File: rtl/dataflow_frame_sequencer.sv
// Top-level ap_ctrl_hs controller for a producer/consumer frame pipeline:
// start gating via frame tokens, busy tracking, frame counting and a stall watchdog.
module dataflow_frame_sequencer #(
    parameter int TOKEN_DEPTH = 2,
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 1000000
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    dataflow_frame_sequencer_if.slave bus
);
    localparam logic [3:0]  DEPTH      = 4'(TOKEN_DEPTH);
    localparam logic [31:0] STALL_TRIP = 32'(STALL_LIMIT - 1);

    logic [3:0]       tokens_q, tokens_d;
    logic             p0_busy_q, p0_busy_d;
    logic             p1_busy_q, p1_busy_d;
    logic             ap_done_q, ap_done_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic [31:0]      wd_cnt_q, wd_cnt_d;
    logic             stall_q, stall_d;
    logic [1:0]       stall_vec_q, stall_vec_d;

    logic p0_start_raw;
    logic p1_start_raw;
    logic p0_acc;
    logic p1_acc;
    logic progress;
    logic wd_count_en;

    always_comb begin
        p0_start_raw = bus.ap_start && (tokens_q < DEPTH);
        p1_start_raw = (tokens_q != 4'd0);
        p0_acc       = p0_start_raw && bus.p0_ready;
        p1_acc       = p1_start_raw && bus.p1_ready;
        progress     = p0_acc || p1_acc || bus.p0_done || bus.p1_done;
        wd_count_en  = (p0_busy_q || p1_busy_q) && !progress && !bus.clr_stall;
    end

    always_comb begin
        tokens_d = tokens_q;
        case ({bus.p0_done, p1_acc})
            2'b10:   tokens_d = tokens_q + 4'd1;
            2'b01:   tokens_d = tokens_q - 4'd1;
            default: tokens_d = tokens_q;
        endcase

        // A done and a fresh accept in one cycle means a new frame is already running.
        p0_busy_d = p0_acc || (p0_busy_q && !bus.p0_done);
        p1_busy_d = p1_acc || (p1_busy_q && !bus.p1_done);

        ap_done_d = bus.p1_done;
        frames_d  = bus.p1_done ? frames_q + 1'b1 : frames_q;
    end

    always_comb begin
        wd_cnt_d    = 32'd0;
        stall_d     = stall_q;
        stall_vec_d = stall_vec_q;
        if (wd_count_en && (wd_cnt_q != '1))
            wd_cnt_d = wd_cnt_q + 32'd1;
        if (bus.clr_stall) begin
            stall_d     = 1'b0;
            stall_vec_d = 2'b00;
        end else if (wd_count_en && !stall_q && (wd_cnt_q == STALL_TRIP)) begin
            stall_d     = 1'b1;
            stall_vec_d = {p1_busy_q, p0_busy_q};
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            tokens_q    <= 4'd0;
            p0_busy_q   <= 1'b0;
            p1_busy_q   <= 1'b0;
            ap_done_q   <= 1'b0;
            frames_q    <= '0;
            wd_cnt_q    <= 32'd0;
            stall_q     <= 1'b0;
            stall_vec_q <= 2'b00;
        end else begin
            tokens_q    <= tokens_d;
            p0_busy_q   <= p0_busy_d;
            p1_busy_q   <= p1_busy_d;
            ap_done_q   <= ap_done_d;
            frames_q    <= frames_d;
            wd_cnt_q    <= wd_cnt_d;
            stall_q     <= stall_d;
            stall_vec_q <= stall_vec_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign bus.p0_start    = p0_start_raw && !ap_rst;
    assign bus.p1_start    = p1_start_raw && !ap_rst;
    assign bus.ap_ready    = p0_acc && !ap_rst;
    assign bus.ap_idle     = !ap_rst && !bus.ap_start && !p0_busy_q && !p1_busy_q &&
                             bus.p0_idle && bus.p1_idle && (tokens_q == 4'd0) && !ap_done_q;
    assign bus.ap_done     = ap_done_q;
    assign bus.tokens      = tokens_q;
    assign bus.frames_done = frames_q;
    assign bus.stall       = stall_q;
    assign bus.stall_vec   = stall_vec_q;

    token_overflow_a: assert property (@(posedge ap_clk) disable iff (ap_rst)
        !(bus.p0_done && (tokens_q == DEPTH) && !p1_acc));

endmodule

// File: doc/dataflow_frame_sequencer.md
Name: dataflow_frame_sequencer

Overview:
Top-level dataflow controller for the two-process video pipeline: the test-pattern producer (P0) feeding the Mat2AXIvideo consumer (P1) through the pixel stream FIFOs.
- Implements the top ap_ctrl_hs handshake.
- Issues per-process start and tracks ready/done.
- Limits producer run-ahead with a frame-token counter.
- Provides a stall watchdog that flags which process is hung.
- Sits between the host control interface and the two process instances.

Parameters:
TOKEN_DEPTH, 2, max frames P0 may complete ahead of P1 acceptance (1..15)
CNT_W, 16, width of completed-frame counter
STALL_LIMIT, 1000000, cycles without progress before stall is flagged (fits 32 bits)

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst  in  1  asynchronous active-high reset
ap_start  in  1  top start request, held until ap_ready
ap_ready  out  1  pulse: current invocation accepted by P0
ap_done  out  1  pulse: one frame fully output by P1
ap_idle  out  1  pipeline empty and no request pending
p0_start  out  1  start to producer
p0_ready  in  1  producer accepted start
p0_done  in  1  producer finished a frame
p0_idle  in  1  producer idle
p1_start  out  1  start to consumer
p1_ready  in  1  consumer accepted start
p1_done  in  1  consumer finished a frame
p1_idle  in  1  consumer idle
tokens  out  4  frames produced, not yet accepted by P1
frames_done  out  CNT_W  completed frame count, wraps
clr_stall  in  1  synchronous clear of stall flags
stall  out  1  sticky watchdog flag
stall_vec  out  2  busy snapshot at stall: [0]=P0, [1]=P1

Behaviour:
Reset:
- ap_rst high clears asynchronously: tokens, frames_done, busy flags, watchdog counter, stall, stall_vec, ap_done register.
- All outputs read 0 while ap_rst is high, including p0_start, p1_start, ap_ready and ap_idle. The ap_idle gating overrides the combinational formula.
- No state survives a mid-frame reset. Children are reset by the same ap_rst.

Start and accept:
- p0_start = ap_start & (tokens < TOKEN_DEPTH), combinational.
- P0 accept event = p0_start & p0_ready. ap_ready = P0 accept event (combinational, same cycle).
- p1_start = (tokens != 0), combinational.
- P1 accept event = p1_start & p1_ready.

Token counter:
- +1 on p0_done; -1 on P1 accept; simultaneous events leave it unchanged.
- Never exceeds TOKEN_DEPTH, never underflows. This is guaranteed by the start gating.
- Assertion: p0_done while tokens == TOKEN_DEPTH and no P1 accept is an error.

Busy flags:
- p0_busy sets on P0 accept and clears on p0_done. If both occur in the same cycle, the flag stays set (new frame started).
- p1_busy uses the same rules with P1 accept and p1_done.

Done and frame count:
- ap_done is registered: a 1-cycle pulse the cycle after p1_done.
- frames_done increments on the same edge that raises ap_done. It wraps from 2^CNT_W-1 to 0.

Idle:
- ap_idle = ~ap_start & ~p0_busy & ~p1_busy & p0_idle & p1_idle & (tokens == 0) & ~ap_done_reg.

Watchdog:
- Progress event = any of: P0 accept, P1 accept, p0_done, p1_done.
- Counter clears on a progress event or when neither process is busy. Otherwise it increments each cycle (saturating).
- When the counter reaches STALL_LIMIT with stall = 0: stall sets and stall_vec captures {p1_busy, p0_busy}.
- stall and stall_vec then hold until clr_stall or ap_rst. If clr_stall and the trigger condition coincide, clr_stall wins and the counter restarts from 0.
- stall has no effect on sequencing.

Test Plan:
1. Single frame: ap_start=1 at t0 with p0_ready=1 -> ap_ready pulses at t0; deassert ap_start. p0_done at t0+10 -> tokens=1, p1_start=1. p1_ready=1 at t0+11 -> tokens=0. p1_done at t0+30 -> ap_done pulse at t0+31, frames_done=1, ap_idle=1 at t0+32.
2. Backpressure: TOKEN_DEPTH=2, ap_start held, p1_ready=0, P0 completes frames -> after 2nd p0_done, tokens=2 and p0_start=0. A single P1 accept drops tokens to 1 and p0_start returns to 1 the same cycle.
3. Simultaneous events: tokens=1, p0_done and P1 accept in the same cycle -> tokens stays 1. p0_done coinciding with a new P0 accept keeps p0_busy=1.
4. Watchdog: STALL_LIMIT=16, P0 accepted, no further events -> stall=1 and stall_vec=2'b01 after 16 idle-progress cycles. clr_stall -> stall=0 next cycle; re-fires 16 cycles later.
5. Reset mid-operation: tokens=2, both busy, stall=1, assert ap_rst between clock edges -> tokens, stall, p0_start, p1_start, ap_idle read 0 immediately. After release: ap_idle=1 with children idle, frames_done=0.
6. Counter wrap: CNT_W=4, run 17 frames back-to-back -> frames_done reads 15 after the 15th frame, 0 after the 16th, 1 after the 17th; ap_done pulses 17 times.
